// File: rtl/i2c_seq_ctrl_pkg.sv
// Shared definitions for the i2c_master_top sequencer: register map of the
// core, CR/SR bit positions, response error codes and sequencer FSM states.
package i2c_seq_pkg;

  localparam logic [2:0] ADR_PRERLO = 3'd0;
  localparam logic [2:0] ADR_PRERHI = 3'd1;
  localparam logic [2:0] ADR_CTR    = 3'd2;
  localparam logic [2:0] ADR_TXR    = 3'd3;
  localparam logic [2:0] ADR_RXR    = 3'd3;
  localparam logic [2:0] ADR_CR     = 3'd4;
  localparam logic [2:0] ADR_SR     = 3'd4;

  // Command register bits
  localparam int CR_STA = 7;
  localparam int CR_STO = 6;
  localparam int CR_RD  = 5;
  localparam int CR_WR  = 4;
  localparam int CR_ACK = 3;

  // Status register bits
  localparam int SR_RXACK = 7;
  localparam int SR_AL    = 5;
  localparam int SR_TIP   = 1;

  // Core enabled, interrupt disabled
  localparam logic [7:0] CTR_EN = 8'h80;

  typedef enum logic [1:0] {
    ERR_OK      = 2'd0,
    ERR_NACK    = 2'd1,
    ERR_AL      = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_e;

  typedef enum logic [3:0] {
    ST_INIT_PLO, ST_INIT_PHI, ST_INIT_CTR, ST_IDLE,
    ST_TXR, ST_CR, ST_POLL, ST_CHECK, ST_RXR,
    ST_ABORT, ST_ABORT_POLL, ST_DONE
  } state_e;

  function automatic logic [7:0] cr_flags(input logic sta, input logic sto,
                                          input logic rd, input logic wr,
                                          input logic ack);
    logic [7:0] b;
    b = 8'h00;
    b[CR_STA] = sta;
    b[CR_STO] = sto;
    b[CR_RD]  = rd;
    b[CR_WR]  = wr;
    b[CR_ACK] = ack;
    return b;
  endfunction

endpackage

// File: rtl/i2c_seq_ctrl_wb_master_port.sv
// Single wishbone access engine. A start pulse latches adr/dat/we and raises
// cyc/stb; they are held until ack, dropped on the following cycle, and done
// pulses in that same cycle with the data captured on the ack cycle.
// Ports: wb_clk_i/wb_rst_i (sync, active high); start/we/adr/wdat request;
// done/rdat completion; m_wb_* wishbone master signals.
module i2c_wb_master_port (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       start,
  input  logic       we,
  input  logic [2:0] adr,
  input  logic [7:0] wdat,
  output logic       done,
  output logic [7:0] rdat,
  output logic [2:0] m_wb_adr_o,
  output logic [7:0] m_wb_dat_o,
  input  logic [7:0] m_wb_dat_i,
  output logic       m_wb_we_o,
  output logic       m_wb_stb_o,
  output logic       m_wb_cyc_o,
  input  logic       m_wb_ack_i
);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      done       <= 1'b0;
      rdat       <= 8'h00;
      m_wb_adr_o <= 3'd0;
      m_wb_dat_o <= 8'h00;
      m_wb_we_o  <= 1'b0;
      m_wb_stb_o <= 1'b0;
      m_wb_cyc_o <= 1'b0;
    end else begin
      done <= 1'b0;
      if (m_wb_cyc_o) begin
        if (m_wb_ack_i) begin
          m_wb_cyc_o <= 1'b0;
          m_wb_stb_o <= 1'b0;
          m_wb_we_o  <= 1'b0;
          rdat       <= m_wb_dat_i;
          done       <= 1'b1;
        end
      end else if (start) begin
        m_wb_cyc_o <= 1'b1;
        m_wb_stb_o <= 1'b1;
        m_wb_we_o  <= we;
        m_wb_adr_o <= adr;
        m_wb_dat_o <= wdat;
      end
    end
  end

endmodule

// File: rtl/i2c_seq_ctrl.sv
// Sequencer for i2c_master_top. Programs the prescaler and enables the core
// after reset, then runs single-register write / random-read commands as full
// START/address/data/STOP sequences by TIP polling, returning data + error.
// Ports: wb_clk_i/wb_rst_i; cmd_* request (valid/ready); rsp_* one-cycle
// response; m_wb_* wishbone master to the core.
module i2c_seq_ctrl
  import i2c_seq_pkg::*;
#(
  parameter logic [15:0] PRESCALE     = 16'h0004,
  parameter logic [15:0] POLL_TIMEOUT = 16'd4095
) (
  input  logic       wb_clk_i,
  input  logic       wb_rst_i,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rw,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic [1:0] rsp_err,
  output logic [2:0] m_wb_adr_o,
  output logic [7:0] m_wb_dat_o,
  input  logic [7:0] m_wb_dat_i,
  output logic       m_wb_we_o,
  output logic       m_wb_stb_o,
  output logic       m_wb_cyc_o,
  input  logic       m_wb_ack_i
);

  state_e      state;
  err_e        err_q;
  logic        rw_q;
  logic [6:0]  dev_q;
  logic [7:0]  reg_q, wdata_q, rx_q;
  logic [1:0]  step_q;
  logic [15:0] poll_cnt, poll_nxt;
  logic        sr_al, sr_rxack;
  logic        acc_start, acc_pend, acc_done;
  logic [7:0]  acc_rdat;
  logic        is_acc, acc_we;
  logic [2:0]  acc_adr;
  logic [7:0]  acc_wdat, txr_byte, cr_byte;
  logic [1:0]  last_step;

  assign poll_nxt  = (poll_cnt == 16'hFFFF) ? poll_cnt : poll_cnt + 16'd1;
  assign last_step = rw_q ? 2'd3 : 2'd2;

  // Per-step TXR/CR bytes; step 2 of a read is the repeated START, step 3
  // receives the byte with NACK and STOP.
  always_comb begin
    txr_byte = {dev_q, 1'b0};
    cr_byte  = cr_flags(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    case (step_q)
      2'd1: begin
        txr_byte = reg_q;
        cr_byte  = cr_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      end
      2'd2: begin
        txr_byte = rw_q ? {dev_q, 1'b1} : wdata_q;
        cr_byte  = rw_q ? cr_flags(1'b1, 1'b0, 1'b0, 1'b1, 1'b0)
                        : cr_flags(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      end
      2'd3: cr_byte = cr_flags(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
      default: ;
    endcase
  end

  // Wishbone access wanted by the current state
  always_comb begin
    is_acc   = 1'b1;
    acc_we   = 1'b1;
    acc_adr  = ADR_CR;
    acc_wdat = 8'h00;
    case (state)
      ST_INIT_PLO: begin acc_adr = ADR_PRERLO; acc_wdat = PRESCALE[7:0];  end
      ST_INIT_PHI: begin acc_adr = ADR_PRERHI; acc_wdat = PRESCALE[15:8]; end
      ST_INIT_CTR: begin acc_adr = ADR_CTR;    acc_wdat = CTR_EN;         end
      ST_TXR:      begin acc_adr = ADR_TXR;    acc_wdat = txr_byte;       end
      ST_CR:       acc_wdat = cr_byte;
      ST_ABORT:    acc_wdat = cr_flags(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      ST_POLL, ST_ABORT_POLL: begin acc_we = 1'b0; acc_adr = ADR_SR;  end
      ST_RXR:                 begin acc_we = 1'b0; acc_adr = ADR_RXR; end
      default: is_acc = 1'b0;
    endcase
  end

  i2c_wb_master_port u_port (
    .wb_clk_i   (wb_clk_i),
    .wb_rst_i   (wb_rst_i),
    .start      (acc_start),
    .we         (acc_we),
    .adr        (acc_adr),
    .wdat       (acc_wdat),
    .done       (acc_done),
    .rdat       (acc_rdat),
    .m_wb_adr_o (m_wb_adr_o),
    .m_wb_dat_o (m_wb_dat_o),
    .m_wb_dat_i (m_wb_dat_i),
    .m_wb_we_o  (m_wb_we_o),
    .m_wb_stb_o (m_wb_stb_o),
    .m_wb_cyc_o (m_wb_cyc_o),
    .m_wb_ack_i (m_wb_ack_i)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= ST_INIT_PLO;
      err_q     <= ERR_OK;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_err   <= 2'd0;
      rw_q      <= 1'b0;
      dev_q     <= 7'd0;
      reg_q     <= 8'h00;
      wdata_q   <= 8'h00;
      rx_q      <= 8'h00;
      step_q    <= 2'd0;
      poll_cnt  <= 16'd0;
      sr_al     <= 1'b0;
      sr_rxack  <= 1'b0;
      acc_start <= 1'b0;
      acc_pend  <= 1'b0;
    end else begin
      // Each access state issues exactly one access; acc_pend blocks a
      // re-issue until done, which also guarantees an idle bus cycle.
      acc_start <= 1'b0;
      if (is_acc && !acc_pend) begin
        acc_start <= 1'b1;
        acc_pend  <= 1'b1;
      end
      if (acc_done) acc_pend <= 1'b0;

      case (state)
        ST_INIT_PLO: if (acc_done) state <= ST_INIT_PHI;
        ST_INIT_PHI: if (acc_done) state <= ST_INIT_CTR;
        ST_INIT_CTR: if (acc_done) state <= ST_IDLE;
        ST_IDLE: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rw_q      <= cmd_rw;
            dev_q     <= cmd_dev;
            reg_q     <= cmd_reg;
            wdata_q   <= cmd_wdata;
            rx_q      <= 8'h00;
            step_q    <= 2'd0;
            err_q     <= ERR_OK;
            state     <= ST_TXR;
          end
        end
        ST_TXR: if (acc_done) state <= ST_CR;
        ST_CR: if (acc_done) begin
          poll_cnt <= 16'd0;
          state    <= ST_POLL;
        end
        ST_POLL: if (acc_done) begin
          poll_cnt <= poll_nxt;
          sr_al    <= acc_rdat[SR_AL];
          sr_rxack <= acc_rdat[SR_RXACK];
          if (!acc_rdat[SR_TIP]) state <= ST_CHECK;
          else if (poll_nxt >= POLL_TIMEOUT) begin
            err_q <= ERR_TIMEOUT;
            state <= ST_ABORT;
          end
        end
        ST_CHECK: begin
          if (sr_al) begin
            // Core has already released the bus; no STOP.
            err_q <= ERR_AL;
            state <= ST_DONE;
          end else if (cr_byte[CR_WR] && sr_rxack) begin
            err_q <= ERR_NACK;
            state <= ST_ABORT;
          end else if (step_q == last_step) begin
            state <= rw_q ? ST_RXR : ST_DONE;
          end else begin
            step_q <= step_q + 2'd1;
            state  <= (rw_q && step_q == 2'd2) ? ST_CR : ST_TXR;
          end
        end
        ST_RXR: if (acc_done) begin
          rx_q  <= acc_rdat;
          state <= ST_DONE;
        end
        ST_ABORT: if (acc_done) begin
          poll_cnt <= 16'd0;
          state    <= ST_ABORT_POLL;
        end
        ST_ABORT_POLL: if (acc_done) begin
          poll_cnt <= poll_nxt;
          if (!acc_rdat[SR_TIP] || poll_nxt >= POLL_TIMEOUT) state <= ST_DONE;
        end
        ST_DONE: begin
          rsp_valid <= 1'b1;
          rsp_err   <= err_q;
          rsp_rdata <= (err_q == ERR_OK) ? rx_q : 8'h00;
          state     <= ST_IDLE;
        end
        default: state <= ST_INIT_PLO;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_seq_ctrl.sv
// Bench for i2c_seq_ctrl with a behavioural model of the i2c_master_top
// register file and bus: expected wishbone writes, bus events and responses
// are queued with each command and compared against what the model observes.
module tb_i2c_seq_ctrl;

  localparam int EV_S  = 256;
  localparam int EV_SR = 257;
  localparam int EV_P  = 258;
  localparam int EV_W  = 512;
  localparam int EV_RA = 768;
  localparam int EV_RN = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0, cmd_rw = 1'b0;
  logic [6:0] cmd_dev = 7'd0;
  logic [7:0] cmd_reg = 8'h00, cmd_wdata = 8'h00;
  logic       cmd_ready, rsp_valid;
  logic [7:0] rsp_rdata;
  logic [1:0] rsp_err;
  logic [2:0] m_wb_adr_o;
  logic [7:0] m_wb_dat_o, m_wb_dat_i;
  logic       m_wb_we_o, m_wb_stb_o, m_wb_cyc_o, m_wb_ack_i;

  always #5 clk = ~clk;

  i2c_seq_ctrl #(.PRESCALE(16'h0004), .POLL_TIMEOUT(16'd16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_dat_i(m_wb_dat_i),
    .m_wb_we_o(m_wb_we_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_cyc_o(m_wb_cyc_o),
    .m_wb_ack_i(m_wb_ack_i)
  );

  // ---------------- core + slave model ----------------
  logic       nack_mode = 1'b0, al_mode = 1'b0, stuck = 1'b0;
  logic [7:0] slave_byte = 8'h00;
  logic [7:0] prer_lo = 8'h00, prer_hi = 8'h00, ctr = 8'h00, txr = 8'h00, rxr = 8'h00;
  logic       ack = 1'b0, prev_cyc = 1'b0, bus_busy = 1'b0, al = 1'b0, rxack = 1'b0, stuck_tip = 1'b0;
  logic [7:0] rd_dat = 8'h00;
  int         tip_cnt = 0, n_txr = 0, n_sr = 0, sr_at_abort = 0, gap_viol = 0, n_rsp = 0;
  logic [10:0] obs_wr[$];
  int          obs_bus[$];

  assign m_wb_ack_i = ack;
  assign m_wb_dat_i = rd_dat;

  always @(posedge clk) begin
    if (rst) begin
      ack <= 1'b0; tip_cnt <= 0; stuck_tip <= 1'b0;
      bus_busy <= 1'b0; al <= 1'b0; rxack <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (m_wb_cyc_o && m_wb_stb_o && !ack) begin
        ack <= 1'b1;
        if (prev_cyc) gap_viol <= gap_viol + 1;
        if (m_wb_we_o) begin
          obs_wr.push_back({m_wb_adr_o, m_wb_dat_o});
          case (m_wb_adr_o)
            3'd0: prer_lo <= m_wb_dat_o;
            3'd1: prer_hi <= m_wb_dat_o;
            3'd2: ctr <= m_wb_dat_o;
            3'd3: begin txr <= m_wb_dat_o; n_txr <= n_txr + 1; end
            3'd4: begin
              if (m_wb_dat_o[7]) begin
                obs_bus.push_back(bus_busy ? EV_SR : EV_S);
                bus_busy <= 1'b1; al <= 1'b0;
              end
              if (m_wb_dat_o[4] && al_mode) begin
                al <= 1'b1; bus_busy <= 1'b0;
              end else begin
                if (m_wb_dat_o[4]) begin
                  obs_bus.push_back(EV_W + int'(txr));
                  rxack <= nack_mode;
                end
                if (m_wb_dat_o[5]) begin
                  obs_bus.push_back((m_wb_dat_o[3] ? EV_RN : EV_RA) + int'(slave_byte));
                  rxr <= slave_byte;
                end
                if (m_wb_dat_o[6]) begin
                  obs_bus.push_back(EV_P); bus_busy <= 1'b0;
                end
              end
              if (m_wb_dat_o == 8'h40) sr_at_abort <= n_sr;
              stuck_tip <= stuck && (m_wb_dat_o[4] || m_wb_dat_o[5]);
              tip_cnt   <= (!stuck && (m_wb_dat_o[4] || m_wb_dat_o[5])) ? 2 : 0;
            end
            default: ;
          endcase
        end else begin
          case (m_wb_adr_o)
            3'd0: rd_dat <= prer_lo;
            3'd1: rd_dat <= prer_hi;
            3'd2: rd_dat <= ctr;
            3'd3: rd_dat <= rxr;
            default: begin
              rd_dat <= {rxack, bus_busy, al, 3'b000, (stuck_tip || tip_cnt != 0), 1'b0};
              if (tip_cnt != 0) tip_cnt <= tip_cnt - 1;
              n_sr <= n_sr + 1;
            end
          endcase
        end
      end
    end
    prev_cyc <= m_wb_cyc_o;
    if (rsp_valid) n_rsp <= n_rsp + 1;
  end

  // ---------------- scoreboard ----------------
  int          errors = 0, checks = 0;
  logic [10:0] exp_wr[$];
  int          exp_bus[$];
  logic [9:0]  exp_rsp[$];

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic ew(input logic [2:0] a, input logic [7:0] d);
    exp_wr.push_back({a, d});
  endtask

  task automatic drain(input string tag);
    logic [10:0] o, e;
    int ob, eb;
    while (obs_wr.size() > 0) begin
      o = obs_wr.pop_front();
      e = (exp_wr.size() > 0) ? exp_wr.pop_front() : 11'h7FF;
      chk({tag, "_wb"}, 16'(o), 16'(e));
    end
    chk({tag, "_wb_missing"}, 16'(exp_wr.size()), 16'd0);
    while (obs_bus.size() > 0) begin
      ob = obs_bus.pop_front();
      eb = (exp_bus.size() > 0) ? exp_bus.pop_front() : 4095;
      chk({tag, "_bus"}, 16'(ob), 16'(eb));
    end
    chk({tag, "_bus_missing"}, 16'(exp_bus.size()), 16'd0);
    chk({tag, "_idle_gap"}, 16'(gap_viol), 16'd0);
    exp_wr.delete();
    exp_bus.delete();
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (!cmd_ready && n < 2000) begin @(negedge clk); n++; end
    chk({tag, "_ready"}, 16'(cmd_ready), 16'd1);
  endtask

  task automatic send(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                      input logic [7:0] wd, input logic [1:0] e_err, input logic [7:0] e_dat);
    exp_rsp.push_back({e_err, e_dat});
    wait_ready("send");
    cmd_valid = 1'b1; cmd_rw = rw; cmd_dev = dev; cmd_reg = rg; cmd_wdata = wd;
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("accept_ready_drop", 16'(cmd_ready), 16'd0);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    logic [9:0] e;
    while (!rsp_valid && n < 3000) begin @(negedge clk); n++; end
    chk({tag, "_rsp_valid"}, 16'(rsp_valid), 16'd1);
    e = (exp_rsp.size() > 0) ? exp_rsp.pop_front() : 10'h3FF;
    chk({tag, "_rsp"}, 16'({rsp_err, rsp_rdata}), 16'(e));
    @(negedge clk);
    chk({tag, "_rsp_pulse"}, 16'(rsp_valid), 16'd0);
    chk({tag, "_ready_after"}, 16'(cmd_ready), 16'd1);
    drain(tag);
  endtask

  initial begin
    int base, n, rsp0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", 16'({m_wb_cyc_o, m_wb_stb_o, m_wb_we_o, cmd_ready, rsp_valid, rsp_err, m_wb_adr_o}), 16'd0);
    chk("reset_data", {rsp_rdata, m_wb_dat_o}, 16'd0);

    // init
    ew(3'd0, 8'h04); ew(3'd1, 8'h00); ew(3'd2, 8'h80);
    rst = 1'b0;
    wait_ready("init");
    drain("init");
    chk("init_prerlo", 16'(prer_lo), 16'h0004);
    chk("init_ctr", 16'(ctr), 16'h0080);

    // write
    ew(3, 8'hA0); ew(4, 8'h90); ew(3, 8'h12); ew(4, 8'h10); ew(3, 8'hA5); ew(4, 8'h50);
    exp_bus = '{EV_S, EV_W + 'hA0, EV_W + 'h12, EV_W + 'hA5, EV_P};
    send(1'b0, 7'h50, 8'h12, 8'hA5, 2'd0, 8'h00);
    wait_rsp("write");

    // read
    slave_byte = 8'h3C;
    ew(3, 8'hA0); ew(4, 8'h90); ew(3, 8'h12); ew(4, 8'h10); ew(3, 8'hA1); ew(4, 8'h90); ew(4, 8'h68);
    exp_bus = '{EV_S, EV_W + 'hA0, EV_W + 'h12, EV_SR, EV_W + 'hA1, EV_RN + 'h3C, EV_P};
    send(1'b1, 7'h50, 8'h12, 8'h00, 2'd0, 8'h3C);
    wait_rsp("read");

    // address NACK
    nack_mode = 1'b1;
    ew(3, 8'hA0); ew(4, 8'h90); ew(4, 8'h40);
    exp_bus = '{EV_S, EV_W + 'hA0, EV_P};
    send(1'b1, 7'h50, 8'h12, 8'h00, 2'd1, 8'h00);
    wait_rsp("nack");
    nack_mode = 1'b0;

    // arbitration lost on the address byte
    al_mode = 1'b1;
    ew(3, 8'hA0); ew(4, 8'h90);
    exp_bus = '{EV_S};
    send(1'b0, 7'h50, 8'h12, 8'h77, 2'd2, 8'h00);
    wait_rsp("arb_lost");
    al_mode = 1'b0;

    // clock stretched forever: poll timeout
    stuck = 1'b1;
    base = n_sr;
    ew(3, 8'hA0); ew(4, 8'h90); ew(4, 8'h40);
    exp_bus = '{EV_S, EV_W + 'hA0, EV_P};
    send(1'b0, 7'h50, 8'h12, 8'h77, 2'd3, 8'h00);
    wait_rsp("timeout");
    chk("timeout_sr_reads", 16'(sr_at_abort - base), 16'd16);
    stuck = 1'b0;

    // reset during the second byte of a write
    ew(3, 8'hA0); ew(4, 8'h90); ew(3, 8'h12);
    exp_bus = '{EV_S, EV_W + 'hA0};
    wait_ready("midrst");
    base = n_txr;
    rsp0 = n_rsp;
    cmd_valid = 1'b1; cmd_rw = 1'b0; cmd_dev = 7'h50; cmd_reg = 8'h12; cmd_wdata = 8'hA5;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (n_txr < base + 2 && n < 2000) begin @(negedge clk); n++; end
    chk("midrst_reached", 16'(n_txr - base), 16'd2);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_drop", 16'({m_wb_cyc_o, m_wb_stb_o, cmd_ready}), 16'd0);
    repeat (3) @(negedge clk);
    drain("midrst");
    ew(3'd0, 8'h04); ew(3'd1, 8'h00); ew(3'd2, 8'h80);
    rst = 1'b0;
    wait_ready("reinit");
    drain("reinit");
    chk("midrst_no_rsp", 16'(n_rsp - rsp0), 16'd0);
    chk("rsp_queue_empty", 16'(exp_rsp.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_seq_ctrl.md
Name: i2c_seq_ctrl

Overview:
- Wishbone master that configures and sequences i2c_master_top through its register file (PRERlo/PRERhi/CTR/TXR/RXR/CR/SR at addresses 0-4).
- After reset it programs the prescaler and enables the core.
- It then accepts single-register I2C commands (write or random-read of one byte at dev/reg) and executes each as the full START/address/data/STOP sequence.
- It returns a response with read data and an error code; it sits between system logic and the i2c_master_top wishbone slave port.

Parameters:
- PRESCALE, 16'h0004, value written to PRERhi:PRERlo (SCL = wb_clk/(5*(PRESCALE+1))).
- POLL_TIMEOUT, 16'd4095, maximum SR reads per byte transfer before aborting.

Ports:
- wb_clk_i  in  1  clock; shared with i2c_master_top.
- wb_rst_i  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block idle and initialised; the command is accepted on cmd_valid&&cmd_ready.
- cmd_rw  in  1  0=write, 1=read.
- cmd_dev  in  7  7-bit slave address.
- cmd_reg  in  8  slave register address.
- cmd_wdata  in  8  write data (ignored for reads).
- rsp_valid  out  1  one-cycle pulse at command completion.
- rsp_rdata  out  8  read byte (0 for writes or on error).
- rsp_err  out  2  0=ok, 1=NACK, 2=arbitration lost, 3=timeout.
- m_wb_adr_o  out  3  register address to the core.
- m_wb_dat_o  out  8  write data to the core.
- m_wb_dat_i  in  8  read data from the core.
- m_wb_we_o  out  1  write enable.
- m_wb_stb_o  out  1  strobe.
- m_wb_cyc_o  out  1  cycle.
- m_wb_ack_i  in  1  acknowledge from the core.

Behaviour:
- Reset: all outputs 0; FSM enters INIT_PLO. A reset mid-transfer drops cyc/stb on the next edge and discards the command with no response.
- Wishbone access (every register op):
  - Drive adr/dat/we with cyc=stb=1 and hold them until m_wb_ack_i.
  - Deassert cyc/stb the cycle after ack; latch m_wb_dat_i on the ack cycle.
  - No back-to-back strobes: at least one idle cycle between accesses. No timeout on ack.
- Init sequence:
  - INIT_PLO writes adr0 = PRESCALE[7:0].
  - INIT_PHI writes adr1 = PRESCALE[15:8].
  - INIT_CTR writes adr2 = 8'h80 (EN=1, IEN=0).
  - Then IDLE.
- IDLE: cmd_ready=1. On accept, latch the cmd fields and deassert cmd_ready in the next cycle.
- Byte step (shared sub-sequence): write TXR (adr3), then write CR (adr4) with the flag byte, then POLL.
  - CR flag bits: STA=7, STO=6, RD=5, WR=4, ACK=3.
  - RD steps skip the TXR write.
- POLL:
  - Read SR (adr4) repeatedly until TIP (bit1)=0.
  - Each read increments a poll counter; the counter is cleared at each step.
  - If the counter reaches POLL_TIMEOUT, go to ABORT with err=3.
- CHECK, on the final SR value:
  - AL (bit5)=1 → DONE with err=2. No STOP is issued; the core already released the bus.
  - Else, after a WR step, RxACK (bit7)=1 → ABORT with err=1.
- Write command steps:
  - TXR={dev,0}, CR=8'h90.
  - TXR=reg, CR=8'h10.
  - TXR=wdata, CR=8'h50 (WR+STO).
- Read command steps:
  - TXR={dev,0}, CR=8'h90.
  - TXR=reg, CR=8'h10.
  - TXR={dev,1}, CR=8'h90 (repeated START).
  - CR=8'h68 (RD+ACK=NACK+STO), poll, then read RXR (adr3) into rsp_rdata.
- ABORT: write CR=8'h40 (STO), poll until TIP=0 under the same timeout rule (a second timeout keeps err=3), then DONE.
- DONE:
  - rsp_valid=1 for one cycle with rsp_err and rsp_rdata.
  - Next cycle → IDLE with cmd_ready=1.
  - The earliest next-command accept is the cycle after the rsp_valid pulse.
- Widths: the poll counter is 16 bits and saturates. The TXR address byte is {cmd_dev, rw_bit}.
- The block never reads SR.IF and never sets IACK; completion is by TIP polling only.

Decomposition:
- Package i2c_seq_pkg:
  - Register address constants: ADR_PRERLO=0, ADR_PRERHI=1, ADR_CTR=2, ADR_TXR/RXR=3, ADR_CR/SR=4.
  - CR bit positions and SR bit positions.
  - Error code enum.
  - FSM state enum.
- One sub-module: i2c_wb_master_port. It performs a single wishbone read/write access with a start/done handshake, and the sequencer FSM drives it.

Test Plan:
- Reset release with PRESCALE=4 → three wishbone writes in order: adr0=0x04, adr1=0x00, adr2=0x80; then cmd_ready=1. The core reads back PRERlo=0x04 and CTR=0x80.
- Write cmd dev=0x50, reg=0x12, wdata=0xA5 with an ACKing slave model → the slave receives bytes 0xA0, 0x12, 0xA5 followed by STOP; rsp_valid pulse with err=0 and rdata=0.
- Read cmd dev=0x50, reg=0x12, slave returns 0x3C → bus shows 0xA0, 0x12, Sr, 0xA1, data 0x3C, master NACK, STOP; rsp_rdata=0x3C, err=0.
- Slave NACKs the address byte → no further TXR writes, a CR=0x40 write occurs, bus shows STOP, rsp_err=1, then cmd_ready=1.
- Hold scl_pad_i low (clock stretch forever) with POLL_TIMEOUT=16 → exactly 16 SR reads, then STOP is attempted; rsp_err=3.
- Assert wb_rst_i during the second byte of a write → cyc/stb=0 and cmd_ready=0 on the next edge; no rsp_valid; the init sequence reruns after release.
